logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the core's combinational logical unit.
- Executes bitwise, shift/rotate and (optionally) bit-count operations on WIDTH-bit operands.
- Uses a valid/ready handshake, carries a tag, and supports flush.
- Sits in the execute stage beside the adder; the issue stage drives it and writeback/bypass consumes it.

Parameters:
- WIDTH, 32, operand/result width; legal values 32 or 64.
- TAG_W, 5, width of the opaque tag (destination register index) carried with each op.
- SHAMT_W, $clog2(WIDTH), derived shift-amount width; not overridable.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  reset; asynchronous, active-high
- flush_i  input  1  kill all in-flight ops
- in_valid_i  input  1  request valid
- in_ready_o  output  1  unit can accept a request
- funct_i  input  4  operation select (lu_funct_e)
- op1_i  input  WIDTH  operand 1
- op2_i  input  WIDTH  operand 2; low SHAMT_W bits are the shift amount for shift/rotate ops
- tag_i  input  TAG_W  request tag
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- res_o  output  WIDTH  result
- tag_o  output  TAG_W  tag of the result
- illegal_o  output  1  funct was reserved or disabled; res_o is 0

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, out_valid_o=0, res_o=0, tag_o=0, illegal_o=0. in_ready_o is 1 one cycle after reset deasserts.
- Reset mid-operation: all in-flight ops are discarded.
- Stage 1 (S1): on in_valid_i && in_ready_o, register funct, op1, op2 and tag; set s1_valid.
- Stage 2 (S2): compute the result from the S1 registers and register res, tag and illegal into the output register; set s2_valid.
- Output: out_valid_o = s2_valid.
- Latency and throughput: latency is 2 cycles from accept to out_valid_o with no backpressure. Throughput is 1 op/cycle.
- Backpressure:
  - s2_ready = !s2_valid || out_ready_i.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready_o = s1_ready.
- Stalled stages hold their contents stable, and out payload holds while out_valid_o && !out_ready_i.
- Simultaneous accept into S1 and drain from S2 in the same cycle is legal; no bubble is inserted.
- flush_i: synchronously clears s1_valid and s2_valid. A request presented in the same cycle as flush_i is dropped. in_ready_o stays 1 during flush.
- funct encoding (4'dN):
  - 0 AND; 1 OR; 2 XOR; 3 ANDN (op1 & ~op2); 4 ORN; 5 XNOR.
  - 6 SLL; 7 SRL; 8 SRA (arithmetic, sign = op1[WIDTH-1]).
  - 9 ROL; 10 ROR; 11 PASS (res=op2).
  - 12 CLZ; 13 CTZ; 14 CPOP; 15 reserved.
- Shift/rotate amounts: only op2[SHAMT_W-1:0] is used; upper bits are ignored. A rotate by 0 returns op1.
- CLZ/CTZ of 0 return WIDTH.
- Reserved or disabled funct: res=0, illegal_o=1. The op still flows through the pipe with normal latency and handshake.

Optional Feature:
- Macro: LOGIC_BITCNT_EN.
- Defined: funct 12/13/14 produce CLZ/CTZ/CPOP, zero-extended to WIDTH.
- Undefined: funct 12–14 behave as reserved (res=0, illegal_o=1) and no count logic is synthesised.

Decomposition:
- Shared package (proc_pkg), which holds:
  - the lu_funct_e enum with the encodings above;
  - LU_FUNCT_W=4.
- Sub-module lu_bitcnt (combinational CLZ/CTZ/CPOP, parametrised on WIDTH), instantiated only under LOGIC_BITCNT_EN.
- Shifts and rotates stay inline, as one right-shifter with operand reversal.

Test Plan:
- Basic ops, WIDTH=32, back-to-back, out_ready_i=1:
  - AND 0xF0F0_1234 & 0x0FF0_FFFF -> 0x00F0_1234, 2 cycles after accept.
  - XNOR 0xAAAA_AAAA,0x5555_5555 -> 0x0000_0000.
  - Tags 1,2,3 emerge in order on consecutive cycles.
- Shift/rotate:
  - SRA 0x8000_0000 by op2=0xFFFF_FFE4 (shamt 4) -> 0xF800_0000.
  - ROR 0x0000_0001 by 1 -> 0x8000_0000.
  - SLL by 0 -> op1 unchanged.
- Backpressure:
  - Hold out_ready_i=0 for 5 cycles with 3 requests offered: 2 accepted, then in_ready_o=0.
  - res_o/tag_o are stable throughout.
  - On release, all 3 results arrive in order with none lost or duplicated.
- Flush:
  - flush_i asserted with both stages full and a new request offered -> next cycle out_valid_o=0.
  - The flushed request never appears.
  - The following request completes normally with 2-cycle latency.
- Bit-count and reserved ops:
  - With LOGIC_BITCNT_EN: CLZ 0x0001_0000 -> 15; CTZ 0 -> 32; CPOP 0xFFFF_0000 -> 16.
  - Without the macro: funct 12 -> res 0, illegal_o=1.
  - funct 15 -> illegal_o=1 in both builds.
- Reset and width:
  - rst_i asserted asynchronously mid-stream -> out_valid_o=0 immediately, with no clock edge.
  - WIDTH=64: SRL 0x8000_0000_0000_0000 by 63 -> 1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared execute-stage definitions: logical-unit operation encodings.
package proc_pkg;

  localparam int LU_FUNCT_W = 4;

  typedef enum logic [LU_FUNCT_W-1:0] {
    LU_AND  = 4'd0,
    LU_OR   = 4'd1,
    LU_XOR  = 4'd2,
    LU_ANDN = 4'd3,
    LU_ORN  = 4'd4,
    LU_XNOR = 4'd5,
    LU_SLL  = 4'd6,
    LU_SRL  = 4'd7,
    LU_SRA  = 4'd8,
    LU_ROL  = 4'd9,
    LU_ROR  = 4'd10,
    LU_PASS = 4'd11,
    LU_CLZ  = 4'd12,
    LU_CTZ  = 4'd13,
    LU_CPOP = 4'd14,
    LU_RSVD = 4'd15
  } lu_funct_e;

endpackage

// File: rtl/lu_bitcnt.sv
// Combinational leading-zero, trailing-zero and population counts,
// each zero-extended to WIDTH. A zero input gives CLZ = CTZ = WIDTH.
module lu_bitcnt #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] clz_o,
  output logic [WIDTH-1:0] ctz_o,
  output logic [WIDTH-1:0] cpop_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] clz;
  logic [CNT_W-1:0] ctz;
  logic [CNT_W-1:0] cpop;
  logic             seen_hi;
  logic             seen_lo;

  always_comb begin
    clz     = '0;
    ctz     = '0;
    cpop    = '0;
    seen_hi = 1'b0;
    seen_lo = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      // Count zeros until the first set bit seen from each end.
      if (!seen_hi) begin
        if (a_i[WIDTH-1-i]) seen_hi = 1'b1;
        else                clz     = clz + CNT_W'(1);
      end
      if (!seen_lo) begin
        if (a_i[i]) seen_lo = 1'b1;
        else        ctz     = ctz + CNT_W'(1);
      end
      if (a_i[i]) cpop = cpop + CNT_W'(1);
    end
  end

  assign clz_o  = {{(WIDTH-CNT_W){1'b0}}, clz};
  assign ctz_o  = {{(WIDTH-CNT_W){1'b0}}, ctz};
  assign cpop_o = {{(WIDTH-CNT_W){1'b0}}, cpop};

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logical unit: bitwise, shift/rotate and optional bit counts.
// Define LOGIC_BITCNT_EN to enable CLZ/CTZ/CPOP; otherwise funct 12-14 are illegal.
module logic_unit_pipe
  import proc_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int TAG_W   = 5,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LU_FUNCT_W-1:0] funct_i,
  input  logic [WIDTH-1:0]      op1_i,
  input  logic [WIDTH-1:0]      op2_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      res_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  illegal_o
);

  // Handshake: a transfer happens on a cycle where valid && ready; a producer
  // holds valid and payload stable until it transfers, and ready never waits on valid.
  logic s1_ready;
  logic s2_ready;
  logic accept;
  logic advance;

  logic             s1_valid_q, s1_valid_d;
  lu_funct_e        s1_funct_q, s1_funct_d;
  logic [WIDTH-1:0] s1_op1_q,   s1_op1_d;
  logic [WIDTH-1:0] s1_op2_q,   s1_op2_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q,      res_d;
  logic [TAG_W-1:0] tag_q,      tag_d;
  logic             illegal_q,  illegal_d;

  logic [WIDTH-1:0] res_c;
  logic             illegal_c;

  assign s2_ready   = !s2_valid_q || out_ready_i;
  assign s1_ready   = !s1_valid_q || s2_ready;
  assign in_ready_o = s1_ready || flush_i;
  assign accept     = in_valid_i && s1_ready && !flush_i;
  assign advance    = s1_valid_q && s2_ready && !flush_i;

  // Shifts and rotates share one right shifter; left forms reverse in and out.
  logic [SHAMT_W-1:0] shamt;
  logic               is_left;
  logic               is_rot;
  logic [WIDTH-1:0]   op1_rev;
  logic [WIDTH-1:0]   sh_src;
  logic [WIDTH-1:0]   sh_hi;
  logic [2*WIDTH-1:0] sh_wide;
  logic [WIDTH-1:0]   sh_out;
  logic [WIDTH-1:0]   sh_out_rev;
  logic [WIDTH-1:0]   sh_res;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign op1_rev[i]    = s1_op1_q[WIDTH-1-i];
    assign sh_out_rev[i] = sh_out[WIDTH-1-i];
  end

  always_comb begin
    shamt   = s1_op2_q[SHAMT_W-1:0];
    is_left = (s1_funct_q == LU_SLL) || (s1_funct_q == LU_ROL);
    is_rot  = (s1_funct_q == LU_ROL) || (s1_funct_q == LU_ROR);
    sh_src  = is_left ? op1_rev : s1_op1_q;
    if (is_rot)                    sh_hi = sh_src;
    else if (s1_funct_q == LU_SRA) sh_hi = {WIDTH{s1_op1_q[WIDTH-1]}};
    else                           sh_hi = '0;
    sh_wide = {sh_hi, sh_src} >> shamt;
    sh_out  = sh_wide[WIDTH-1:0];
    sh_res  = is_left ? sh_out_rev : sh_out;
  end

`ifdef LOGIC_BITCNT_EN
  logic [WIDTH-1:0] clz;
  logic [WIDTH-1:0] ctz;
  logic [WIDTH-1:0] cpop;

  lu_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .a_i    (s1_op1_q),
    .clz_o  (clz),
    .ctz_o  (ctz),
    .cpop_o (cpop)
  );
`endif

  always_comb begin
    res_c     = '0;
    illegal_c = 1'b0;
    case (s1_funct_q)
      LU_AND:  res_c = s1_op1_q & s1_op2_q;
      LU_OR:   res_c = s1_op1_q | s1_op2_q;
      LU_XOR:  res_c = s1_op1_q ^ s1_op2_q;
      LU_ANDN: res_c = s1_op1_q & ~s1_op2_q;
      LU_ORN:  res_c = s1_op1_q | ~s1_op2_q;
      LU_XNOR: res_c = ~(s1_op1_q ^ s1_op2_q);
      LU_SLL, LU_SRL, LU_SRA, LU_ROL, LU_ROR: res_c = sh_res;
      LU_PASS: res_c = s1_op2_q;
`ifdef LOGIC_BITCNT_EN
      LU_CLZ:  res_c = clz;
      LU_CTZ:  res_c = ctz;
      LU_CPOP: res_c = cpop;
`endif
      default: illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_funct_d = s1_funct_q;
    s1_op1_d   = s1_op1_q;
    s1_op2_d   = s1_op2_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    tag_d      = tag_q;
    illegal_d  = illegal_q;

    if (s1_ready) s1_valid_d = accept;
    if (accept) begin
      s1_funct_d = lu_funct_e'(funct_i);
      s1_op1_d   = op1_i;
      s1_op2_d   = op2_i;
      s1_tag_d   = tag_i;
    end

    if (s2_ready) s2_valid_d = s1_valid_q;
    if (advance) begin
      res_d     = res_c;
      tag_d     = s1_tag_q;
      illegal_d = illegal_c;
    end

    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_funct_q <= LU_AND;
      s1_op1_q   <= '0;
      s1_op2_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      tag_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_funct_q <= s1_funct_d;
      s1_op1_q   <= s1_op1_d;
      s1_op2_q   <= s1_op2_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      tag_q      <= tag_d;
      illegal_q  <= illegal_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign res_o       = res_q;
  assign tag_o       = tag_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed steps plus randomized ops scored against
// a behavioural model; a second 64-bit instance covers the wide shifter.
module tb_logic_unit_pipe;
  import proc_pkg::*;

  localparam int W  = 32;
  localparam int SH = 5;
  localparam int TW = 5;
  localparam int EW = 1 + TW + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [3:0]    funct_i;
  logic [W-1:0]  op1_i;
  logic [W-1:0]  op2_i;
  logic [TW-1:0] tag_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  res_o;
  logic [TW-1:0] tag_o;
  logic          illegal_o;

  logic          in_valid64;
  logic          in_ready64;
  logic [3:0]    funct64;
  logic [63:0]   op1_64;
  logic [63:0]   op2_64;
  logic [TW-1:0] tag_in64;
  logic          out_valid64;
  logic [63:0]   res64;
  logic [TW-1:0] tag64;
  logic          illegal64;

  logic_unit_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .funct_i     (funct_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .res_o       (res_o),
    .tag_o       (tag_o),
    .illegal_o   (illegal_o)
  );

  logic_unit_pipe #(.WIDTH(64), .TAG_W(TW)) u_dut64 (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (1'b0),
    .in_valid_i  (in_valid64),
    .in_ready_o  (in_ready64),
    .funct_i     (funct64),
    .op1_i       (op1_64),
    .op2_i       (op2_64),
    .tag_i       (tag_in64),
    .out_valid_o (out_valid64),
    .out_ready_i (1'b1),
    .res_o       (res64),
    .tag_o       (tag64),
    .illegal_o   (illegal64)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur_exp;
  logic [EW-1:0] exp_item;
  logic          acc_seen;
  logic          rand_bp;
  int            n_tests;
  int            n_fail;

  // Reference model: {illegal, result} from the operation definitions.
  function automatic logic [W:0] model(input logic [3:0] f, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int sh;
    int c;
    logic [W-1:0] r;
    logic ill;
    sh  = int'(b[SH-1:0]);
    c   = 0;
    r   = '0;
    ill = 1'b0;
    case (f)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = a & ~b;
      4'd4:  r = a | ~b;
      4'd5:  r = ~(a ^ b);
      4'd6:  r = a << sh;
      4'd7:  r = a >> sh;
      4'd8:  r = $signed(a) >>> sh;
      4'd9:  r = (a << sh) | (a >> (W - sh));
      4'd10: r = (a >> sh) | (a << (W - sh));
      4'd11: r = b;
`ifdef LOGIC_BITCNT_EN
      4'd12: begin
        while (c < W && a[W-1-c] == 1'b0) c++;
        r = W'(c);
      end
      4'd13: begin
        while (c < W && a[c] == 1'b0) c++;
        r = W'(c);
      end
      4'd14: r = W'($countones(a));
`endif
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = '0;
      2:       v = '1;
      default: v = W'(1) << $urandom_range(0, W-1);
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, required %0h", name, obs, exp);
    end
  endtask

  // One cycle: score handshakes at the negedge, then land 1 time unit after posedge.
  task automatic step();
    @(negedge clk);
    acc_seen = 1'b0;
    if (!rst_i) begin
      if (out_valid_o && out_ready_i) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $error("FAIL sb_unexpected: got tag %0d res %0h, required no output", tag_o, res_o);
        end else begin
          exp_item = exp_q.pop_front();
          assert ({illegal_o, tag_o, res_o} === exp_item)
          else begin
            n_fail++;
            $error("FAIL sb_result: got %0h, required %0h", {illegal_o, tag_o, res_o}, exp_item);
          end
        end
      end
      if (flush_i) exp_q.delete();
      else if (in_valid_i && in_ready_o) begin
        exp_q.push_back(cur_exp);
        acc_seen = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rand_bp) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic present(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t);
    logic [W:0] m;
    m          = model(f, a, b);
    funct_i    = f;
    op1_i      = a;
    op2_i      = b;
    tag_i      = t;
    in_valid_i = 1'b1;
    cur_exp    = {m[W], t, m[W-1:0]};
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 64; i++) begin
      step();
      if (acc_seen) break;
    end
    check("accept_timeout", 64'(acc_seen), 64'd1);
  endtask

  task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t);
    present(f, a, b, t);
    wait_accept();
  endtask

  task automatic send_dir(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t, input logic [W-1:0] r, input logic ill);
    present(f, a, b, t);
    cur_exp = {ill, t, r};
    wait_accept();
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [W:0]   m_a;
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           gap;

    n_tests = 0;
    n_fail  = 0;
    rand_bp = 1'b0;
    rst_i   = 1'b1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    funct_i = '0;
    op1_i   = '0;
    op2_i   = '0;
    tag_i   = '0;
    cur_exp = '0;
    in_valid64 = 1'b0;
    funct64  = '0;
    op1_64   = '0;
    op2_64   = '0;
    tag_in64 = '0;

    // Reset state
    step();
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_res", 64'(res_o), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);
    step();
    rst_i = 1'b0;
    step();
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Basic ops back-to-back, 2-cycle latency, tags in order
    send_dir(LU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1, 32'h00F0_1234, 1'b0);
    check("lat_not_yet", 64'(out_valid_o), 64'd0);
    send_dir(LU_XNOR, 32'hAAAA_AAAA, 32'h5555_5555, 5'd2, 32'h0000_0000, 1'b0);
    check("lat_valid", 64'(out_valid_o), 64'd1);
    check("order_tag1", 64'(tag_o), 64'd1);
    send_dir(LU_XOR, 32'h1234_5678, 32'hFFFF_0000, 5'd3, 32'hEDCB_5678, 1'b0);
    check("order_tag2", 64'(tag_o), 64'd2);
    idle();
    step();
    check("order_tag3", 64'(tag_o), 64'd3);
    step();
    check("order_drained", 64'(out_valid_o), 64'd0);

    // Shift / rotate, reserved and bit-count ops (scored at the output)
    send_dir(LU_SRA, 32'h8000_0000, 32'hFFFF_FFE4, 5'd4, 32'hF800_0000, 1'b0);
    send_dir(LU_ROR, 32'h0000_0001, 32'h0000_0001, 5'd5, 32'h8000_0000, 1'b0);
    send_dir(LU_SLL, 32'hC001_D00D, 32'h0000_0020, 5'd6, 32'hC001_D00D, 1'b0);
    send_dir(LU_ROL, 32'h8000_0001, 32'h0000_0000, 5'd7, 32'h8000_0001, 1'b0);
`ifdef LOGIC_BITCNT_EN
    send_dir(LU_CLZ, 32'h0001_0000, 32'h0, 5'd8, 32'd15, 1'b0);
    send_dir(LU_CTZ, 32'h0000_0000, 32'h0, 5'd9, 32'd32, 1'b0);
    send_dir(LU_CPOP, 32'hFFFF_0000, 32'h0, 5'd10, 32'd16, 1'b0);
`else
    send_dir(LU_CLZ, 32'h0001_0000, 32'h0, 5'd8, 32'd0, 1'b1);
    send_dir(LU_CPOP, 32'hFFFF_0000, 32'h0, 5'd10, 32'd0, 1'b1);
`endif
    send_dir(LU_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b1);
    idle();
    repeat (4) step();
    check("directed_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: 2 accepted, third held, payload stable, all 3 delivered
    out_ready_i = 1'b0;
    m_a = model(LU_OR, 32'h1234_0000, 32'h0000_00FF);
    send(LU_OR, 32'h1234_0000, 32'h0000_00FF, 5'd12);
    send(LU_ANDN, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 5'd13);
    present(LU_ROL, 32'h8000_0003, 32'd4, 5'd14);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", 64'(in_ready_o), 64'd0);
      check("bp_valid", 64'(out_valid_o), 64'd1);
      check("bp_res_stable", 64'(res_o), 64'(m_a[W-1:0]));
      check("bp_tag_stable", 64'(tag_o), 64'd12);
    end
    out_ready_i = 1'b1;
    wait_accept();
    idle();
    repeat (4) step();
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Flush with both stages full and a new request offered
    out_ready_i = 1'b0;
    send(LU_XOR, 32'hAAAA_0000, 32'h0000_5555, 5'd15);
    send(LU_PASS, 32'h0, 32'h1357_9BDF, 5'd16);
    present(LU_AND, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd17);
    flush_i = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready_o), 64'd1);
    step();
    check("flush_out_valid", 64'(out_valid_o), 64'd0);
    flush_i = 1'b0;
    idle();
    out_ready_i = 1'b1;
    step();
    check("flush_stays_empty", 64'(out_valid_o), 64'd0);
    send(LU_SRL, 32'h8000_0000, 32'd31, 5'd18);
    check("post_flush_lat0", 64'(out_valid_o), 64'd0);
    idle();
    step();
    check("post_flush_lat2", 64'(out_valid_o), 64'd1);
    check("post_flush_tag", 64'(tag_o), 64'd18);
    step();
    check("flush_drain", 64'(exp_q.size()), 64'd0);

    // Randomized ops with random gaps and random backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      f = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      send(f, a, b, TW'($urandom));
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        idle();
        repeat (gap) step();
      end
    end
    idle();
    rand_bp = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) step();
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-stream
    send(LU_OR, 32'h1, 32'h2, 5'd20);
    send(LU_AND, 32'h3, 32'h6, 5'd21);
    idle();
    check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid_o), 64'd0);
    check("async_rst_res", 64'(res_o), 64'd0);
    exp_q.delete();
    #1;
    rst_i = 1'b0;
    step();
    check("post_rst_valid", 64'(out_valid_o), 64'd0);
    check("post_rst_ready", 64'(in_ready_o), 64'd1);
    step();
    check("post_rst_still_empty", 64'(out_valid_o), 64'd0);

    // 64-bit instance: SRL by 63
    check("w64_in_ready", 64'(in_ready64), 64'd1);
    funct64    = LU_SRL;
    op1_64     = 64'h8000_0000_0000_0000;
    op2_64     = 64'd63;
    tag_in64   = 5'd22;
    in_valid64 = 1'b1;
    step();
    in_valid64 = 1'b0;
    step();
    check("w64_valid", 64'(out_valid64), 64'd1);
    check("w64_srl63", res64, 64'd1);
    check("w64_tag", 64'(tag64), 64'd22);
    check("w64_illegal", 64'(illegal64), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
